// File: rtl/m_unit_ctrl.sv
// RV32M sequencer: one-cycle multiply, 32-step restoring divide plus sign fix-up, registered result with a done pulse.
// Latency start->done: 2 cycles (mul), 34 cycles (div); start is ignored while busy, kill aborts without done.
`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH
`define MUX_MULTA_LENGTH     2
`define MUX_MULTA_ZERO       2'd0
`define MUX_MULTA_R_UNSIGNED 2'd1
`define MUX_MULTA_R_SIGNED   2'd2
`define MUX_MULTB_LENGTH     2
`define MUX_MULTB_ZERO       2'd0
`define MUX_MULTB_D_UNSIGNED 2'd1
`define MUX_MULTB_D_SIGNED   2'd2
`define MUX_DIV_REM_LENGTH   1
`define MUX_DIV_REM_Z        1'b0
`define MUX_DIV_REM_R        1'b1
`endif

module m_unit_ctrl (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          kill,
  input  logic [2:0]                    funct3,
  input  logic [31:0]                   rs1,
  input  logic [31:0]                   rs2,
  input  logic                          sub_neg,
  input  logic [31:0]                   sub_result,
  input  logic [31:0]                   div_rem,
  input  logic [31:0]                   div_rem_neg,
  input  logic [63:0]                   product,
  output logic [`MUX_MULTA_LENGTH-1:0]   mux_multA,
  output logic [`MUX_MULTB_LENGTH-1:0]   mux_multB,
  output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
  output logic [31:0]                   R,
  output logic [62:0]                   D,
  output logic [31:0]                   Z,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] r_q, r_d, z_q, z_d, result_q, result_d;
  logic [62:0] d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_high_q, op_high_d, sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic        is_rem_q, is_rem_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic        done_q, done_d;
  logic        signed_op;
  logic [31:0] abs1, abs2;

  // Magnitudes for signed divide; 0x80000000 maps to itself, read as unsigned.
  assign signed_op = ~funct3[0];
  assign abs1 = (signed_op && rs1[31]) ? (~rs1 + 32'd1) : rs1;
  assign abs2 = (signed_op && rs2[31]) ? (~rs2 + 32'd1) : rs2;

  always_comb begin
    mux_multA   = `MUX_MULTA_ZERO;
    mux_multB   = `MUX_MULTB_ZERO;
    mux_div_rem = `MUX_DIV_REM_Z;
    if (state_q == S_MUL) begin
      mux_multA = sign_a_q ? `MUX_MULTA_R_SIGNED : `MUX_MULTA_R_UNSIGNED;
      mux_multB = sign_b_q ? `MUX_MULTB_D_SIGNED : `MUX_MULTB_D_UNSIGNED;
    end
    if (state_q == S_FIX && is_rem_q) mux_div_rem = `MUX_DIV_REM_R;
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    d_d       = d_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    op_high_d = op_high_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_rem_d  = is_rem_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    result_d  = result_q;
    done_d    = 1'b0;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            z_d = 32'd0;
            if (!funct3[2]) begin
              r_d       = rs1;
              d_d       = {rs2, 31'd0};
              op_high_d = (funct3 != 3'd0);
              sign_a_d  = (funct3 == 3'd1) || (funct3 == 3'd2);
              sign_b_d  = (funct3 == 3'd1);
              state_d   = S_MUL;
            end else begin
              r_d      = abs1;
              d_d      = {abs2, 31'd0};
              cnt_d    = 5'd31;
              is_rem_d = funct3[1];
              neg_q_d  = signed_op & (rs1[31] ^ rs2[31]) & (|rs2);
              neg_r_d  = signed_op & rs1[31];
              state_d  = S_DIV;
            end
          end
        end
        S_MUL: begin
          result_d = op_high_q ? product[63:32] : product[31:0];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        S_DIV: begin
          if (!sub_neg) begin
            r_d = sub_result;
            z_d = {z_q[30:0], 1'b1};
          end else begin
            z_d = {z_q[30:0], 1'b0};
          end
          d_d   = d_q >> 1;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = S_FIX;
        end
        default: begin
          result_d = (is_rem_q ? neg_r_q : neg_q_q) ? div_rem_neg : div_rem;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      d_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      op_high_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      d_q       <= d_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
      op_high_q <= op_high_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      is_rem_q  <= is_rem_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign R      = r_q;
  assign D      = d_q;
  assign Z      = z_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_m_unit_ctrl.sv
// Bench for m_unit_ctrl: combinational datapath model, arithmetic reference model and a result scoreboard.
module tb_m_unit_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
  logic        sub_neg;
  logic [31:0] sub_result, div_rem, div_rem_neg;
  logic [63:0] product;
  logic [1:0]  mux_multA, mux_multB;
  logic [0:0]  mux_div_rem;
  logic [31:0] R, Z, result;
  logic [62:0] D;
  logic        busy, done;

  m_unit_ctrl dut (
    .clk(clk), .resetn(resetn), .start(start), .kill(kill), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .sub_neg(sub_neg), .sub_result(sub_result),
    .div_rem(div_rem), .div_rem_neg(div_rem_neg), .product(product),
    .mux_multA(mux_multA), .mux_multB(mux_multB), .mux_div_rem(mux_div_rem),
    .R(R), .D(D), .Z(Z), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Datapath: 64x64 multiplier on extended operands, full-precision subtractor, Z/R negator.
  logic [63:0] op_a, op_b, diff;
  always_comb begin
    op_a = 64'd0;
    op_b = 64'd0;
    if (mux_multA == 2'd1) op_a = {32'd0, R};
    if (mux_multA == 2'd2) op_a = {{32{R[31]}}, R};
    if (mux_multB == 2'd1) op_b = {32'd0, D[62:31]};
    if (mux_multB == 2'd2) op_b = {{32{D[62]}}, D[62:31]};
    product     = op_a * op_b;
    diff        = {32'd0, R} - {1'b0, D};
    sub_neg     = diff[63];
    sub_result  = diff[31:0];
    div_rem     = mux_div_rem[0] ? R : Z;
    div_rem_neg = -div_rem;
  end

  function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 64'd0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  f;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%h expected no done", cyc, result);
      end else begin
        e = sb_q.pop_front();
        checks += 3;
        if (result !== e.res) begin
          errors++;
          $display("FAIL result f3=%0d got=%h exp=%h", e.f, result, e.res);
        end
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL done_latency f3=%0d got_cyc=%0d exp_cyc=%0d", e.f, cyc, e.cyc);
        end
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done got=%b exp=0", busy);
        end
      end
    end
  end

  // Called at posedge+#1; leaves start low after the sampling edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.res = ref_m(f, a, b);
      e.cyc = cyc + (f[2] ? 34 : 2);
      e.f   = f;
      sb_q.push_back(e);
    end
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got=no_done exp=done within 40 cycles");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  localparam int ND = 14;
  logic [2:0]  d_f [ND] = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                            3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd7};
  logic [31:0] d_a [ND] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
  logic [31:0] d_b [ND] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2,
                            32'd2, 32'd2, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    idle(2);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_RDZ", {1'b0, D} | {32'd0, R} | {32'd0, Z}, 64'd0);
    resetn = 1'b1;
    idle(2);

    // Directed vectors issued back-to-back: each start lands in the previous done cycle.
    for (int i = 0; i < ND; i++) begin
      issue(d_f[i], d_a[i], d_b[i], 1'b1);
      wait_done();
    end
    idle(3);

    // kill at DIV cycle 10: idle next cycle, no done, result kept.
    held = result;
    issue(3'd4, 32'd1000, 32'd3, 1'b0);
    idle(8);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", {63'd0, busy}, 64'd0);
    idle(40);
    check("kill_result_kept", {32'd0, result}, {32'd0, held});

    // kill and start together in IDLE: request dropped.
    kill = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 1'b0);
    kill = 1'b0;
    check("kill_start_busy", {63'd0, busy}, 64'd0);
    idle(5);

    // start pulsed mid-divide is ignored.
    issue(3'd5, 32'd12345, 32'd11, 1'b1);
    idle(5);
    issue(3'd0, 32'd7, 32'd7, 1'b0);
    check("busy_during_div", {63'd0, busy}, 64'd1);
    wait_done();
    idle(5);

    // Reset mid-divide clears everything at once.
    issue(3'd6, 32'hFFFF_0000, 32'd17, 1'b0);
    idle(6);
    #2 resetn = 1'b0;
    #1;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_result", {32'd0, result}, 64'd0);
    check("midreset_RDZ", {1'b0, D} | {32'd0, R} | {32'd0, Z}, 64'd0);
    idle(2);
    resetn = 1'b1;
    idle(2);

    // Randomized traffic with occasional idle gaps.
    for (int i = 0; i < 250; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 1'b1);
      wait_done();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_unit_ctrl.md
# m_unit_ctrl

Sequencing controller for the RV32M multiply/divide datapath. It accepts one M-extension operation at a time from the execute stage and owns the datapath operand registers R (remainder/multiplicand), D (divisor/multiplier) and Z (quotient). It drives the datapath mux selects: single-cycle multiply, 32-iteration restoring divide, then sign fix-up. It returns a registered 32-bit result with a one-cycle `done` pulse.

## Interface
- No parameters; width fixed at RV32. Mux encodings are `MUX_*` from m_definitions.svh.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; accepted only on a rising edge where `busy`=0.
- `kill`  in  1  synchronous abort; highest priority after reset.
- `funct3`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, `rs2`  in  32  operands, sampled with `start`.
- `sub_neg`  in  1  datapath: sign of the 63-bit subtraction {31'b0,R} − D.
- `sub_result`  in  32  datapath: low 32 bits of that subtraction.
- `div_rem`, `div_rem_neg`  in  32  datapath: selected Z or R, and its two's complement.
- `product`  in  64  datapath multiplier result.
- `mux_multA`, `mux_multB`  out  `MUX_MULTA_LENGTH`/`MUX_MULTB_LENGTH`  multiplier operand selects.
- `mux_div_rem`  out  `MUX_DIV_REM_LENGTH`  selects Z or R.
- `R`  out  32,  `D`  out  63,  `Z`  out  32  operand registers.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  32  registered result; held until the next `done`.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
- **Reset values:** state IDLE; R, D, Z, `result` = 0; `busy` = 0; `done` = 0.
- **Mux selects outside MUL:** `mux_multA`/`mux_multB` = ZERO.
- **IDLE + start, multiply (funct3[2]=0):**
  - Load R=rs1, D={rs2,31'b0}, Z=0; go to MUL.
  - Latch `op_high` = (funct3≠0), `signA` = funct3∈{1,2}, `signB` = (funct3==1).
- **MUL:**
  - `mux_multA` = R_SIGNED if `signA`, else R_UNSIGNED.
  - `mux_multB` = D_SIGNED if `signB`, else D_UNSIGNED.
  - `result` ← `op_high` ? product[63:32] : product[31:0].
  - Pulse `done`; go to IDLE.
- **IDLE + start, divide (funct3[2]=1):**
  - `signed_op` = ~funct3[0]; `is_rem` = funct3[1].
  - R = |rs1| if signed_op and rs1[31], else rs1.
  - D = {|rs2|, 31'b0}, using the same rule on rs2.
  - Z = 0; iteration counter = 31; go to DIV.
  - Latch `neg_q` = signed_op & (rs1[31]^rs2[31]) & (rs2≠0).
  - Latch `neg_r` = signed_op & rs1[31].
  - |0x80000000| is 0x80000000 as an unsigned value.
- **DIV, each cycle:**
  - If !sub_neg: R←sub_result and Z←{Z[30:0],1}; else Z←{Z[30:0],0}.
  - D←D>>1; counter decrements.
  - When counter==0 (32nd iteration), go to FIX.
- **FIX:**
  - `mux_div_rem` = R if `is_rem`, else Z.
  - `result` ← (is_rem ? neg_r : neg_q) ? div_rem_neg : div_rem.
  - Pulse `done`; go to IDLE.
- **Divide by zero:** needs no special path. Z finishes 0xFFFFFFFF and R finishes |rs1|; fix-up then yields quotient −1 and remainder rs1, as RISC-V requires.
- **Overflow (DIV −2^31/−1):** result 0x80000000; REM gives 0.
- **start while busy:** ignored; no queueing.
- **kill:** state→IDLE next edge, no `done`, `result` unchanged. `kill` and `start` in the same IDLE cycle: `kill` wins, request dropped.
- **resetn low mid-operation:** all state clears immediately; no `done`.

## Timing
- `busy` = (state≠IDLE), combinational from the state register.
- Multiply: `start` sampled at edge 0; MUL during cycle 1; `done`=1 in cycle 2 with `busy`=0.
- Divide: DIV during cycles 1–32, FIX in cycle 33, `done`=1 in cycle 34.
- Back-to-back: `start` is accepted in the same cycle `done` is high.
- Mux selects are combinational from the state and latched flags. The datapath is combinational, so `product`/`div_rem` settle within the same cycle.

## Test plan
- **MULHU:** rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → `done` 2 cycles after start, result 0xFFFFFFFE. MUL with the same operands → 0x00000001.
- **MULH / MULHSU:** MULH rs1=0x80000000, rs2=0x80000000 → 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- **DIV / REM:** DIV rs1=−7, rs2=2 → −3 (0xFFFFFFFD) with `done` at cycle 34. REM −7,2 → 0xFFFFFFFF. DIVU 100,7 → 14. REMU 100,7 → 2.
- **Divide by zero and overflow:** DIV 5,0 → 0xFFFFFFFF. REM 5,0 → 5. DIVU 5,0 → 0xFFFFFFFF. DIV 0x80000000,0xFFFFFFFF → 0x80000000. REM same → 0.
- **Abort and reset:** `kill` at DIV cycle 10 → IDLE next cycle, no `done`, old result kept. `resetn` low mid-DIV → outputs at reset values immediately.
- **Busy and back-to-back:** `start` pulsed during DIV is ignored. `start` asserted in the `done` cycle is accepted with no idle gap.
